// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with one checkpoint slot for recovering the
// top pointer and count after a mispredicted speculative call/return sequence.
module ras_ckpt_stack #(
    parameter  int DEPTH = 2,
    parameter  int VLEN  = 32,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    input  logic            ckpt_i,
    input  logic            restore_i,
    output logic [VLEN-1:0] data_o,
    output logic            valid_o,
    output logic [CW-1:0]   count_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [VLEN-1:0] entries [DEPTH];
    logic [PW-1:0]   tp;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ckpt_tp;
    logic [CW-1:0]   ckpt_cnt;
    logic            ovf_q;
    logic            unf_q;

    logic [PW-1:0]   tp_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            wr_en;
    logic [PW-1:0]   wr_ptr;
    logic            ovf_nxt;
    logic            unf_nxt;
    logic            ckpt_en;

    // Explicit wrap keeps non-power-of-two depths inside 0..DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1 || p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        if (DEPTH == 1) begin
            return '0;
        end
        if (p == '0) begin
            return LAST_PTR;
        end
        return p - 1'b1;
    endfunction

    always_comb begin
        tp_nxt  = tp;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_ptr  = tp;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (flush_i) begin
            tp_nxt  = '0;
            cnt_nxt = '0;
        end else if (restore_i) begin
            tp_nxt  = ckpt_tp;
            cnt_nxt = ckpt_cnt;
        end else if (push_i && pop_i) begin
            // Tail call: the new return address replaces the current top.
            wr_en  = 1'b1;
            wr_ptr = tp;
            if (cnt == '0) begin
                cnt_nxt = CW'(1);
            end
        end else if (push_i) begin
            tp_nxt = ptr_inc(tp);
            wr_en  = 1'b1;
            wr_ptr = ptr_inc(tp);
            if (cnt == FULL_CNT) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else if (pop_i) begin
            if (cnt == '0) begin
                unf_nxt = 1'b1;
            end else begin
                tp_nxt  = ptr_dec(tp);
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    assign ckpt_en = ckpt_i && !flush_i && !restore_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp       <= '0;
            cnt      <= '0;
            ckpt_tp  <= '0;
            ckpt_cnt <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            tp    <= tp_nxt;
            cnt   <= cnt_nxt;
            ovf_q <= ovf_nxt;
            unf_q <= unf_nxt;
            if (ckpt_en) begin
                ckpt_tp  <= tp;
                ckpt_cnt <= cnt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_ptr] <= data_i;
        end
    end

    assign data_o      = entries[tp];
    assign valid_o     = (cnt != '0);
    assign count_o     = cnt;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Randomized and directed checks of ras_ckpt_stack against a queue-free
// array model using modulo arithmetic on plain integers.
module tb_ras_ckpt_stack;

    localparam int DEPTH = 2;
    localparam int VLEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst;
    logic            flush;
    logic            push;
    logic            pop;
    logic [VLEN-1:0] din;
    logic            ckpt;
    logic            restore;
    logic [VLEN-1:0] dout;
    logic            valid;
    logic [CW-1:0]   count;
    logic            ovf;
    logic            unf;

    int compared;
    int mismatched;

    logic [VLEN-1:0] m_mem [DEPTH];
    int              m_tp;
    int              m_cnt;
    int              m_ctp;
    int              m_ccnt;
    logic            m_ovf;
    logic            m_unf;

    ras_ckpt_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .push_i     (push),
        .pop_i      (pop),
        .data_i     (din),
        .ckpt_i     (ckpt),
        .restore_i  (restore),
        .data_o     (dout),
        .valid_o    (valid),
        .count_o    (count),
        .overflow_o (ovf),
        .underflow_o(unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_tp = 0; m_cnt = 0; m_ctp = 0; m_ccnt = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic modelStep(input logic f, input logic r, input logic c,
                             input logic pu, input logic po, input logic [VLEN-1:0] d);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (f) begin
            m_tp = 0; m_cnt = 0;
        end else if (r) begin
            m_tp = m_ctp; m_cnt = m_ccnt;
        end else begin
            if (c) begin
                m_ctp = m_tp; m_ccnt = m_cnt;
            end
            if (pu && po) begin
                m_mem[m_tp] = d;
                if (m_cnt == 0) m_cnt = 1;
            end else if (pu) begin
                if (m_cnt == DEPTH) m_ovf = 1'b1;
                else m_cnt++;
                m_tp = (m_tp + 1) % DEPTH;
                m_mem[m_tp] = d;
            end else if (po) begin
                if (m_cnt == 0) m_unf = 1'b1;
                else begin
                    m_cnt--;
                    m_tp = (m_tp + DEPTH - 1) % DEPTH;
                end
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".count"}, 32'(count), 32'(m_cnt));
        checkOutput({tag, ".valid"}, 32'(valid), 32'(m_cnt != 0));
        checkOutput({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        checkOutput({tag, ".unf"},   32'(unf),   32'(m_unf));
        if (m_cnt != 0) checkOutput({tag, ".data"}, dout, m_mem[m_tp]);
    endtask

    // One clock cycle: drive, step the model at the edge, then compare 1ns later.
    task automatic applyStimulus(input logic f, input logic r, input logic c,
                                 input logic pu, input logic po, input logic [VLEN-1:0] d,
                                 input string tag);
        flush = f; restore = r; ckpt = c; push = pu; pop = po; din = d;
        @(posedge clk);
        modelStep(f, r, c, pu, po, d);
        #1;
        flush = 1'b0; restore = 1'b0; ckpt = 1'b0; push = 1'b0; pop = 1'b0;
        checkAll(tag);
    endtask

    task automatic doPush(input logic [VLEN-1:0] d, input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d, tag);
    endtask

    task automatic doPop(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, tag);
    endtask

    task automatic doFlush();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "flush");
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        flush = 1'b0; push = 1'b0; pop = 1'b0; ckpt = 1'b0; restore = 1'b0; din = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.data",  dout, 32'h0);
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic LIFO
        doPush(32'h100, "lifo1");
        doPush(32'h200, "lifo2");
        checkOutput("lifo.top", dout, 32'h200);
        checkOutput("lifo.cnt2", 32'(count), 32'd2);
        doPop("lifo3");
        checkOutput("lifo.pop1", dout, 32'h100);
        doPop("lifo4");
        checkOutput("lifo.empty", 32'(valid), 32'd0);

        // Overflow wrap
        doPush(32'hA, "ovf1");
        doPush(32'hB, "ovf2");
        doPush(32'hC, "ovf3");
        checkOutput("ovf.pulse", 32'(ovf), 32'd1);
        checkOutput("ovf.top", dout, 32'hC);
        doPop("ovf4");
        checkOutput("ovf.pulse_gone", 32'(ovf), 32'd0);
        checkOutput("ovf.next", dout, 32'hB);
        doPop("ovf5");
        doPop("ovf6");
        checkOutput("ovf.lost", 32'(unf), 32'd1);

        // Underflow
        doFlush();
        doPop("unf1");
        checkOutput("unf.pulse", 32'(unf), 32'd1);
        doPush(32'h40, "unf2");
        checkOutput("unf.pulse_gone", 32'(unf), 32'd0);
        checkOutput("unf.push", dout, 32'h40);

        // Simultaneous push+pop
        doFlush();
        doPush(32'h100, "pp1");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, "pp2");
        checkOutput("pp.top", dout, 32'h300);
        doFlush();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, "pp3");
        checkOutput("pp.empty_cnt", 32'(count), 32'd1);

        // Checkpoint / restore
        doFlush();
        doPush(32'h10, "ck1");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, "ck2");
        doPush(32'h20, "ck3");
        doPop("ck4");
        doPop("ck5");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "ck6");
        checkOutput("ck.restore_cnt", 32'(count), 32'd1);
        checkOutput("ck.restore_top", dout, 32'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h55, "ck7");
        checkOutput("ck.push_dropped", dout, 32'h10);

        // Flush beats restore and push
        doPush(32'h77, "fl1");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h88, "fl2");
        checkOutput("fl.cnt", 32'(count), 32'd0);

        // Asynchronous reset between edges
        doPush(32'h1, "rst1");
        doPush(32'h2, "rst2");
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst.async_data", dout, 32'h0);
        checkAll("rst.async");
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "rst.idle");
        checkOutput("rst.idle_data", dout, 32'h0);
        doPush(32'h99, "rst3");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 31) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 7) == 0,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          $urandom(), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ras_ckpt_stack.md
# ras_ckpt_stack

Parametrised return-address stack for the frontend branch predictor. Depth and address width are set from the core configuration (RAS depth, XLEN). The stack is circular, so overflow silently overwrites the oldest entry. It adds a single checkpoint/restore slot, which recovers the stack pointer after a mispredicted speculative call/return sequence. Flush clears it, for fence.i, exceptions and debug entry.

## Interface
- DEPTH, default 2: number of entries; any value ≥ 1.
- VLEN, default 32: return-address width in bits.
- Derived: PW = max(1, $clog2(DEPTH)) is the pointer width. CW = $clog2(DEPTH+1) is the count width.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high; clears all state immediately.
- flush_i  in  1  empty the stack; highest priority.
- push_i  in  1  call: push data_i.
- pop_i  in  1  return: pop top.
- data_i  in  VLEN  return address to push.
- ckpt_i  in  1  snapshot the current top pointer and count.
- restore_i  in  1  reload the top pointer and count from the snapshot.
- data_o  out  VLEN  top-of-stack address, read combinationally from entry[tp].
- valid_o  out  1  count != 0.
- count_o  out  CW  number of live entries, 0..DEPTH.
- overflow_o  out  1  registered one-cycle pulse: a push overwrote the oldest entry.
- underflow_o  out  1  registered one-cycle pulse: a pop hit an empty stack.

## Operation
- State:
  - entries[DEPTH] of VLEN bits;
  - top pointer tp (PW bits);
  - count (CW bits);
  - ckpt_tp and ckpt_cnt;
  - two pulse flops.
- Pointer arithmetic is modulo DEPTH. For non-power-of-2 depths, wrap explicitly: DEPTH-1 → 0 and 0 → DEPTH-1. When DEPTH=1, tp is constant 0.
- Priority per cycle: flush_i > restore_i > {push_i, pop_i}. ckpt_i is independent, but is ignored when flush_i or restore_i is high.
- flush_i: tp←0, count←0, no pulses. Entry contents are left unchanged.
- restore_i (no flush): tp←ckpt_tp, count←ckpt_cnt. Any push/pop in the same cycle is dropped with no pulses. Entry contents are not restored; entries overwritten since the checkpoint stay overwritten.
- ckpt_i: ckpt_tp←tp and ckpt_cnt←count, using pre-update values, so a push/pop in the same cycle is not included.
- push only:
  - tp←tp+1;
  - entries[tp+1]←data_i;
  - count←min(count+1, DEPTH);
  - if count==DEPTH, overflow_o=1 next cycle.
- pop only, count>0: tp←tp-1, count←count-1.
- pop only, count==0: no state change; underflow_o=1 next cycle.
- push and pop together (call replacing return, tail call):
  - entries[tp]←data_i;
  - tp unchanged;
  - count←max(count,1);
  - no pulses.
- data_o is meaningful only while valid_o=1. When valid_o=0 it shows stale entry contents, which the consumer must ignore.

## Timing
- Reset values:
  - tp=0, count=0, ckpt_tp=0, ckpt_cnt=0, all entries 0;
  - data_o=0, valid_o=0, count_o=0, overflow_o=0, underflow_o=0.
- Reset may assert mid-operation. The same state is forced asynchronously and outputs are zero within the cycle.
- Latency: a push/pop/restore/flush is visible on data_o, valid_o and count_o in the cycle after the edge. There is no same-cycle bypass of data_i to data_o.
- Pulses are high for exactly one cycle, in the cycle after the causing edge, and low otherwise.
- No back-pressure: every request is accepted every cycle.

## Test plan
All scenarios use DEPTH=2, VLEN=32.
- Basic LIFO: after reset, push 0x100 then push 0x200. Expect data_o=0x200, count_o=2. Pop: data_o=0x100, count_o=1. Pop: valid_o=0, count_o=0.
- Overflow wrap: push 0xA, 0xB, 0xC. After 0xC, overflow_o pulses once; count_o=2, data_o=0xC. Pop: data_o=0xB. Pop: valid_o=0; 0xA is lost.
- Underflow: from empty, pop. underflow_o pulses once; count_o=0, and the next push 0x40 gives data_o=0x40, count_o=1.
- Simultaneous push+pop: with top 0x100 (count 1), drive push+pop with data_i=0x300. Expect data_o=0x300, count_o=1, no pulses. Repeat from empty: count_o=1, data_o=0x300.
- Checkpoint/restore:
  - push 0x10, then ckpt_i, then push 0x20, pop, pop, then restore_i: count_o=1, data_o=0x10.
  - restore_i with push_i in the same cycle: push dropped.
- Flush/reset priority:
  - flush_i+push_i+restore_i in the same cycle: count_o=0, valid_o=0.
  - rst_i asserted between edges while count=2: all outputs 0 immediately, and they stay 0 after release until the next push.
